// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG byte-level register paths.
// Holds the default word/byte widths used by both the byte-write register
// and the byte-read serializer, the serializer FSM state type, and a helper
// that derives the number of byte lanes needed to cover a word.
package trng_pkg;

  localparam int TRNG_WORD_WIDTH = 32;
  localparam int TRNG_BYTE_WIDTH = 8;

  typedef enum logic {IDLE, SEND} ser_state_t;

  // Lanes needed to cover w bits in b-bit lanes; a partial top lane counts.
  function automatic int lane_count(input int w, input int b);
    return (w - 1) / b + 1;
  endfunction

endpackage

// File: rtl/byte_next_sel.sv
// Priority encoder that picks the next lane to emit from a mask of
// still-pending lanes.
// Ports:
//   en    in   NBYTES  pending-lane mask
//   idx   out  LW      index of the first pending lane in emission order
//   none  out  1       no lane pending (idx is then 0 and meaningless)
// MSB_FIRST=0 picks the lowest set bit, MSB_FIRST=1 the highest.
module byte_next_sel #(
  parameter int NBYTES    = 4,
  parameter int LW        = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic [NBYTES-1:0] en,
  output logic [LW-1:0]     idx,
  output logic              none
);

  // Loop runs from the lowest-priority end so the last hit is the winner.
  always_comb begin
    idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (en[i]) idx = LW'(i);
      end
    end else begin
      for (int i = NBYTES - 1; i >= 0; i--) begin
        if (en[i]) idx = LW'(i);
      end
    end
  end

  assign none = (en == '0);

endmodule

// File: rtl/byte_read_serializer.sv
// Byte read serializer: takes one WIDTH-bit word over a valid/ready handshake
// and emits it one BYTE_WIDTH lane per handshake on a byte stream for the
// byte-oriented host/UART link. Only one word is held at a time; the next
// word is accepted one cycle after the last byte of the current one is taken.
// Ports:
//   clk           in   1           clock, all flops on posedge
//   rst           in   1           asynchronous active-low reset
//   word_valid_i  in   1           word_i valid
//   word_ready_o  out  1           block can capture a word
//   word_i        in   WIDTH       word to read out
//   byte_en_i     in   NBYTES      lane enables (only with BYTE_READ_MASK_EN)
//   byte_valid_o  out  1           byte_o valid
//   byte_ready_i  in   1           downstream takes byte_o
//   byte_o        out  BYTE_WIDTH  current lane
//   byte_last_o   out  1           byte_o is the final lane of the word
//   busy_o        out  1           a word is held (state SEND)
// Configuration: define BYTE_READ_MASK_EN to add byte_en_i; disabled lanes
// are skipped without costing a cycle. Without it every lane is emitted.
module byte_read_serializer
  import trng_pkg::*;
#(
  parameter int WIDTH      = TRNG_WORD_WIDTH,
  parameter int BYTE_WIDTH = TRNG_BYTE_WIDTH,
  parameter int MSB_FIRST  = 0,
  localparam int NBYTES    = lane_count(WIDTH, BYTE_WIDTH),
  localparam int LW        = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  input  logic [WIDTH-1:0]      word_i,
`ifdef BYTE_READ_MASK_EN
  input  logic [NBYTES-1:0]     byte_en_i,
`endif
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic [BYTE_WIDTH-1:0] byte_o,
  output logic                  byte_last_o,
  output logic                  busy_o
);

  localparam int PW = NBYTES * BYTE_WIDTH;

  ser_state_t state_q, state_d;

  logic [NBYTES-1:0][BYTE_WIDTH-1:0] hold_q, hold_d, word_lanes;
  logic [LW-1:0]                     sel_idx;
  logic                              sel_last;
  logic                              has_lane;
  logic                              accept;

  logic                  word_ready_q, word_ready_d;
  logic                  byte_valid_q, byte_valid_d;
  logic [BYTE_WIDTH-1:0] byte_q, byte_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;

  // Zero-extension pads a partial top lane so its unused bits read 0.
  assign word_lanes = PW'(word_i);
  assign accept     = (state_q == IDLE) && word_valid_i && word_ready_q;

`ifdef BYTE_READ_MASK_EN
  // rem_q holds the enabled lanes not yet emitted, excluding the one on byte_o.
  logic [NBYTES-1:0] rem_q, rem_d, cand, cand_rest;
  logic              sel_none;

  assign cand = (state_q == IDLE) ? byte_en_i : rem_q;

  byte_next_sel #(
    .NBYTES    (NBYTES),
    .LW        (LW),
    .MSB_FIRST (MSB_FIRST)
  ) u_next_sel (
    .en   (cand),
    .idx  (sel_idx),
    .none (sel_none)
  );

  // Lanes left once the selected one is emitted; empty means it is the last.
  always_comb begin
    cand_rest          = cand;
    cand_rest[sel_idx] = 1'b0;
  end

  assign sel_last = (cand_rest == '0);
  assign has_lane = !sel_none;
`else
  localparam logic [LW-1:0] FIRST_LANE = (MSB_FIRST != 0) ? LW'(NBYTES - 1) : '0;
  localparam logic [LW-1:0] FINAL_LANE = (MSB_FIRST != 0) ? '0 : LW'(NBYTES - 1);

  logic [LW-1:0] idx_q, idx_d;

  // Lane to present next: the first lane on accept, else the neighbour
  // of the current lane in emission order.
  always_comb begin
    if (state_q == IDLE) begin
      sel_idx = FIRST_LANE;
    end else if (MSB_FIRST != 0) begin
      sel_idx = idx_q - LW'(1);
    end else begin
      sel_idx = idx_q + LW'(1);
    end
  end

  assign sel_last = (sel_idx == FINAL_LANE);
  assign has_lane = 1'b1;
`endif

  // Next-state and next-output logic; all outputs come straight from flops.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    word_ready_d = word_ready_q;
    byte_valid_d = byte_valid_q;
    byte_d       = byte_q;
    last_d       = last_q;
    busy_d       = busy_q;
`ifdef BYTE_READ_MASK_EN
    rem_d        = rem_q;
`else
    idx_d        = idx_q;
`endif

    case (state_q)
      IDLE: begin
        word_ready_d = 1'b1;
        // A word with no enabled lanes is consumed here and never leaves IDLE.
        if (accept && has_lane) begin
          state_d      = SEND;
          hold_d       = word_lanes;
          byte_d       = word_lanes[sel_idx];
          last_d       = sel_last;
          byte_valid_d = 1'b1;
          word_ready_d = 1'b0;
          busy_d       = 1'b1;
`ifdef BYTE_READ_MASK_EN
          rem_d        = cand_rest;
`else
          idx_d        = sel_idx;
`endif
        end
      end

      SEND: begin
        if (byte_ready_i) begin
          if (last_q) begin
            state_d      = IDLE;
            byte_valid_d = 1'b0;
            byte_d       = '0;
            last_d       = 1'b0;
            busy_d       = 1'b0;
            word_ready_d = 1'b1;
          end else begin
            byte_d = hold_q[sel_idx];
            last_d = sel_last;
`ifdef BYTE_READ_MASK_EN
            rem_d  = cand_rest;
`else
            idx_d  = sel_idx;
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, hold register, lane tracking and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      word_ready_q <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef BYTE_READ_MASK_EN
      rem_q        <= '0;
`else
      idx_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      word_ready_q <= word_ready_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
`ifdef BYTE_READ_MASK_EN
      rem_q        <= rem_d;
`else
      idx_q        <= idx_d;
`endif
    end
  end

  assign word_ready_o = word_ready_q;
  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign byte_last_o  = last_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_byte_read_serializer.sv
// Directed testbench for byte_read_serializer.
// Three instances: default (32-bit, LSB lane first), MSB_FIRST=1, and
// WIDTH=20 (partial top lane). With BYTE_READ_MASK_EN defined the default
// instance also gets a lane-enable test.
module tb_byte_read_serializer;

  logic clk;
  logic rst;

  // Default instance
  logic        v0, r0, rdy0, bv0, l0, busy0;
  logic [31:0] w0;
  logic [7:0]  b0;

  // MSB_FIRST instance
  logic        v1, r1, rdy1, bv1, l1, busy1;
  logic [31:0] w1;
  logic [7:0]  b1;

  // WIDTH=20 instance
  logic        v2, r2, rdy2, bv2, l2, busy2;
  logic [19:0] w2;
  logic [7:0]  b2;

`ifdef BYTE_READ_MASK_EN
  logic [3:0] byteEn;
`endif

  int errors = 0;
  int checks = 0;

  byte_read_serializer u_dut (
    .clk          (clk),
    .rst          (rst),
    .word_valid_i (v0),
    .word_ready_o (rdy0),
    .word_i       (w0),
`ifdef BYTE_READ_MASK_EN
    .byte_en_i    (byteEn),
`endif
    .byte_valid_o (bv0),
    .byte_ready_i (r0),
    .byte_o       (b0),
    .byte_last_o  (l0),
    .busy_o       (busy0)
  );

  byte_read_serializer #(.MSB_FIRST(1)) u_msb (
    .clk          (clk),
    .rst          (rst),
    .word_valid_i (v1),
    .word_ready_o (rdy1),
    .word_i       (w1),
`ifdef BYTE_READ_MASK_EN
    .byte_en_i    (4'hF),
`endif
    .byte_valid_o (bv1),
    .byte_ready_i (r1),
    .byte_o       (b1),
    .byte_last_o  (l1),
    .busy_o       (busy1)
  );

  byte_read_serializer #(.WIDTH(20)) u_w20 (
    .clk          (clk),
    .rst          (rst),
    .word_valid_i (v2),
    .word_ready_o (rdy2),
    .word_i       (w2),
`ifdef BYTE_READ_MASK_EN
    .byte_en_i    (3'b111),
`endif
    .byte_valid_o (bv2),
    .byte_ready_i (r2),
    .byte_o       (b2),
    .byte_last_o  (l2),
    .busy_o       (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] word, input logic ready);
    v0 = valid;
    w0 = word;
    r0 = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Checks the default instance's stream outputs; byte_o only when valid.
  task automatic checkMain(input string tag, input logic expValid, input logic [7:0] expByte,
                           input logic expLast, input logic expReady, input logic expBusy);
    checkOutput({tag, ".valid"}, bv0, expValid);
    if (expValid) checkOutput({tag, ".byte"}, b0, expByte);
    checkOutput({tag, ".last"}, l0, expLast);
    checkOutput({tag, ".ready"}, rdy0, expReady);
    checkOutput({tag, ".busy"}, busy0, expBusy);
  endtask

  initial begin
    logic [7:0] expMsb [4];
    logic [7:0] expW20 [3];
    expMsb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    expW20 = '{8'hDE, 8'hBC, 8'h0A};

    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    v1 = 1'b0; w1 = 32'h0; r1 = 1'b1;
    v2 = 1'b0; w2 = 20'h0; r2 = 1'b1;
`ifdef BYTE_READ_MASK_EN
    byteEn = 4'hF;
`endif

    // Reset state
    #2;
    checkMain("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.byte", b0, 8'h00);
    step();
    step();
    rst = 1'b1;
    #1;
    checkOutput("ready_before_edge", rdy0, 1'b0);
    step();
    checkOutput("ready_after_reset", rdy0, 1'b1);
    checkOutput("idle_no_valid", bv0, 1'b0);

    // Plain word, LSB lane first, downstream always ready
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
    step();
    checkMain("t2.l0", 1'b1, 8'hD4, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkMain("t2.l1", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
    step();
    checkMain("t2.l2", 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
    step();
    checkMain("t2.l3", 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1);
    step();
    checkMain("t2.idle", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Backpressure on C3; a new word offered during SEND must wait
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
    step();
    checkMain("t3.l0", 1'b1, 8'hD4, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkMain("t3.l1", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkMain("t3.stall", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
    step();
    checkMain("t3.l2", 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
    step();
    checkMain("t3.l3", 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1);
    step();
    checkMain("t3.bubble", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    checkMain("t3.next0", 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkMain("t3.next1", 1'b1, 8'hBE, 1'b0, 1'b0, 1'b1);
    step();
    checkMain("t3.next2", 1'b1, 8'hAD, 1'b0, 1'b0, 1'b1);
    step();
    checkMain("t3.next3", 1'b1, 8'hDE, 1'b1, 1'b0, 1'b1);
    step();
    checkMain("t3.idle", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset pulsed after D4, C3 taken; next word restarts at lane 0
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
    step();
    checkMain("t5.l0", 1'b1, 8'hD4, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    step();
    checkMain("t5.l2", 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    checkMain("t5.async", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("t5.async.byte", b0, 8'h00);
    step();
    rst = 1'b1;
    step();
    checkMain("t5.rel", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h11223344, 1'b1);
    step();
    checkMain("t5.n0", 1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkMain("t5.n1", 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    step();
    checkMain("t5.n2", 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    step();
    checkMain("t5.n3", 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    step();
    checkMain("t5.idle", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // MSB_FIRST instance
    checkOutput("msb.ready", rdy1, 1'b1);
    v1 = 1'b1;
    w1 = 32'hA1B2C3D4;
    for (int k = 0; k < 4; k++) begin
      step();
      v1 = 1'b0;
      checkOutput($sformatf("msb.l%0d.valid", k), bv1, 1'b1);
      checkOutput($sformatf("msb.l%0d.byte", k), b1, expMsb[k]);
      checkOutput($sformatf("msb.l%0d.last", k), l1, (k == 3) ? 1'b1 : 1'b0);
    end
    step();
    checkOutput("msb.idle.valid", bv1, 1'b0);
    checkOutput("msb.idle.ready", rdy1, 1'b1);

    // WIDTH=20: partial top lane reads zero in its upper bits
    v2 = 1'b1;
    w2 = 20'hABCDE;
    for (int k = 0; k < 3; k++) begin
      step();
      v2 = 1'b0;
      checkOutput($sformatf("w20.l%0d.valid", k), bv2, 1'b1);
      checkOutput($sformatf("w20.l%0d.byte", k), b2, expW20[k]);
      checkOutput($sformatf("w20.l%0d.last", k), l2, (k == 2) ? 1'b1 : 1'b0);
    end
    step();
    checkOutput("w20.idle.valid", bv2, 1'b0);
    checkOutput("w20.idle.ready", rdy2, 1'b1);
    checkOutput("w20.idle.busy", busy2, 1'b0);

`ifdef BYTE_READ_MASK_EN
    // Only lanes 1 and 3 enabled
    byteEn = 4'b1010;
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
    step();
    checkMain("mask.l1", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkMain("mask.l3", 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1);
    step();
    checkMain("mask.idle", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // No lanes enabled: word swallowed, no byte, ready stays high
    byteEn = 4'b0000;
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
    step();
    checkMain("mask.none0", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkMain("mask.none1", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    byteEn = 4'hF;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
